mem_arbiter_ctrl: RTL and testbench
===================================

// Module: mem_arbiter_ctrl
// PURPOSE
//  Sequences the single shared main-memory port between the I-cache miss path, the D-cache miss path and
//  D-side write-through stores. Grants one requester at a time, streams BLK_WORDS-word block fills into
//  the granted cache, issues single-word writes, and reports busy so the hazard unit stalls the pipeline.
//  Sits between the IF/MEM stage caches and the pipelined memory model.
// PARAMETERS
//  ADDR_W     16  byte-address width
//  DATA_W     16  word width
//  BLK_WORDS  8   words per cache block; power of 2; IDX_W = $clog2(BLK_WORDS)
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  i_miss         in   1       I-cache fill request; level, held until i_fill_done
//  i_miss_addr    in   ADDR_W  I-side miss byte address
//  d_miss         in   1       D-cache fill request; level, held until d_fill_done
//  d_miss_addr    in   ADDR_W  D-side miss byte address
//  d_write        in   1       store request; level, held until d_write_done
//  d_write_addr   in   ADDR_W  store byte address
//  d_write_data   in   DATA_W  store data
//  mem_en         out  1       memory access this cycle
//  mem_wr         out  1       1 = write, 0 = read (valid when mem_en=1)
//  mem_addr       out  ADDR_W  memory byte address
//  mem_wdata      out  DATA_W  memory write data
//  mem_rdata      in   DATA_W  read return data
//  mem_data_valid in   1       mem_rdata valid; one per issued read, in order
//  fill_data      out  DATA_W  = mem_rdata
//  fill_word_idx  out  IDX_W   word index in block of current fill_data
//  i_fill_we      out  1       write fill_data into I-cache
//  d_fill_we      out  1       write fill_data into D-cache
//  i_fill_done    out  1       1-cycle pulse with last I fill word
//  d_fill_done    out  1       1-cycle pulse with last D fill word
//  d_write_done   out  1       1-cycle pulse when store issued to memory
//  busy           out  1       state != IDLE
// BEHAVIOUR
//  - States: IDLE, WRITE, FILL_I, FILL_D. Reset (async): IDLE, counters 0, captured addr 0, all outputs 0.
//  - IDLE: arbitrate on sampled requests; next state registered. Priority d_write > d_miss > i_miss.
//    No request -> stay IDLE. IDLE always lasts >= 1 cycle between grants.
//  - Grant captures address/data into registers; block address = addr with low (IDX_W+1) bits cleared.
//  - WRITE (1 cycle): mem_en=1, mem_wr=1, mem_addr/mem_wdata = captured; d_write_done=1; -> IDLE.
//  - FILL_x: issue_cnt issues reads on consecutive cycles: mem_en=1, mem_wr=0,
//    mem_addr = {blk[ADDR_W-1:IDX_W+1], issue_cnt, 1'b0}; stops after BLK_WORDS issues (mem_en=0).
//  - Returns: ret_cnt counts mem_data_valid in FILL_x; x_fill_we = mem_data_valid (combinational),
//    fill_word_idx = ret_cnt; on ret_cnt == BLK_WORDS-1 with valid: x_fill_done=1, -> IDLE next cycle.
//  - Fill independent of memory latency: with latency L, grant at T, first issue T+1, last return T+8+L.
//  - Requester must drop its request the cycle after its done pulse; the IDLE cycle guarantees no re-grant.
//  - mem_data_valid outside FILL_x (incl. after reset mid-fill) ignored: no fill_we, no count.
//  - Requests arriving while busy wait; requests are not queued, only sampled in IDLE.
//  - Counters wrap to 0 on each grant; never exceed BLK_WORDS-1 (issue) / BLK_WORDS-1 (return).
//  - mem_wdata = 0 except in WRITE; fill_data driven continuously from mem_rdata.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: d_write still highest; between d_miss and i_miss a last-fill flag
//    (reset: I) gives priority to the side not granted last fill; flag updates on each fill grant.
//  Not defined: fixed priority d_write > d_miss > i_miss; i_miss may starve while d_miss persists.
// TESTING
//  1 Reset, no requests -> busy=0, mem_en=0, all done/we outputs 0 for 20 cycles.
//  2 d_write addr 0x1234 data 0xBEEF -> next cycle mem_en=1 mem_wr=1 addr 0x1234 wdata 0xBEEF done=1; then IDLE.
//  3 i_miss addr 0x0046, mem latency 4 -> reads 0x0040..0x004E on 8 cycles; 8 i_fill_we with idx 0..7;
//    i_fill_done with idx 7, 12 cycles after grant; busy low next cycle.
//  4 d_write, d_miss, i_miss all high in IDLE -> order WRITE, FILL_D, FILL_I (round-robin: same for this case).
//  5 d_miss and i_miss held continuously -> fixed: D,D,D...; ARB_ROUND_ROBIN_EN: D,I,D,I alternating.
//  6 rst_n low mid FILL_D after 3 returns -> outputs 0 immediately; late mem_data_valid produces no d_fill_we.

Source files
------------

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl
//   Sequences the single shared main-memory port between the I-cache miss
//   path, the D-cache miss path and D-side write-through stores. One
//   requester is granted at a time. Fills stream BLK_WORDS reads and forward
//   the returned words into the granted cache. Stores issue one write.
//   busy tells the hazard unit to stall the pipeline.
//
//   Optional feature: define ARB_ROUND_ROBIN_EN to alternate fill grants
//   between d_miss and i_miss. Stores keep top priority. Without the macro
//   the fixed priority d_write > d_miss > i_miss applies.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   i_miss / i_miss_addr           I-cache fill request (level) and byte address
//   d_miss / d_miss_addr           D-cache fill request (level) and byte address
//   d_write / _addr / _data        store request (level), address, data
//   mem_en, mem_wr                 memory access strobe, 1 = write
//   mem_addr, mem_wdata            memory byte address, write data
//   mem_rdata, mem_data_valid      in-order read return data and valid
//   fill_data, fill_word_idx       returned word and its index within the block
//   i_fill_we, d_fill_we           cache fill write enables
//   i_fill_done, d_fill_done       pulse with the last fill word
//   d_write_done                   pulse when the store is issued
//   busy                           controller not idle
module mem_arbiter_ctrl #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int BLK_WORDS = 8,
   localparam int IDX_W    = $clog2(BLK_WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_miss,
   input  logic [ADDR_W-1:0] i_miss_addr,
   input  logic              d_miss,
   input  logic [ADDR_W-1:0] d_miss_addr,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_write_addr,
   input  logic [DATA_W-1:0] d_write_data,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_data_valid,
   output logic [DATA_W-1:0] fill_data,
   output logic [IDX_W-1:0]  fill_word_idx,
   output logic              i_fill_we,
   output logic              d_fill_we,
   output logic              i_fill_done,
   output logic              d_fill_done,
   output logic              d_write_done,
   output logic              busy
);

   localparam int LOW_W = IDX_W + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WRITE  = 2'd1;
   localparam logic [1:0] S_FILL_I = 2'd2;
   localparam logic [1:0] S_FILL_D = 2'd3;

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [IDX_W-1:0]  r_issue_cnt;
   logic [IDX_W-1:0]  r_ret_cnt;
   logic              r_issue_done;
`ifdef ARB_ROUND_ROBIN_EN
   logic              r_last_d;   // last fill grant went to the D side
`endif

   logic w_fill;
   logic w_issue;
   logic w_ret;
   logic w_last_ret;
   logic w_grant_w;
   logic w_grant_d;
   logic w_grant_i;

   assign w_fill     = (r_state == S_FILL_I) || (r_state == S_FILL_D);
   assign w_issue    = w_fill && !r_issue_done;
   // Returns only count inside a fill, so stale data after a reset is dropped.
   assign w_ret      = w_fill && mem_data_valid;
   assign w_last_ret = w_ret && (r_ret_cnt == IDX_W'(BLK_WORDS - 1));

   always_comb begin
      w_grant_w = 1'b0;
      w_grant_d = 1'b0;
      w_grant_i = 1'b0;
      if (r_state == S_IDLE) begin
         if (d_write) begin
            w_grant_w = 1'b1;
         end else if (d_miss && i_miss) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_grant_d = !r_last_d;
            w_grant_i = r_last_d;
`else
            w_grant_d = 1'b1;
`endif
         end else begin
            w_grant_d = d_miss;
            w_grant_i = i_miss;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_issue_cnt  <= '0;
         r_ret_cnt    <= '0;
         r_issue_done <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         r_last_d     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_issue_cnt  <= '0;
               r_ret_cnt    <= '0;
               r_issue_done <= 1'b0;
               // Fills keep the full miss address; its low bits are never
               // used because fill addresses are rebuilt from the counter.
               if (w_grant_w) begin
                  r_state <= S_WRITE;
                  r_addr  <= d_write_addr;
                  r_wdata <= d_write_data;
               end else if (w_grant_d) begin
                  r_state <= S_FILL_D;
                  r_addr  <= d_miss_addr;
`ifdef ARB_ROUND_ROBIN_EN
                  r_last_d <= 1'b1;
`endif
               end else if (w_grant_i) begin
                  r_state <= S_FILL_I;
                  r_addr  <= i_miss_addr;
`ifdef ARB_ROUND_ROBIN_EN
                  r_last_d <= 1'b0;
`endif
               end
            end
            S_WRITE: begin
               r_state <= S_IDLE;
            end
            default: begin
               if (w_issue) begin
                  r_issue_cnt <= r_issue_cnt + IDX_W'(1);
                  if (r_issue_cnt == IDX_W'(BLK_WORDS - 1)) begin
                     r_issue_done <= 1'b1;
                  end
               end
               if (w_ret) begin
                  r_ret_cnt <= r_ret_cnt + IDX_W'(1);
                  if (w_last_ret) begin
                     r_state <= S_IDLE;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (r_state == S_WRITE) begin
         mem_en    = 1'b1;
         mem_wr    = 1'b1;
         mem_addr  = r_addr;
         mem_wdata = r_wdata;
      end else if (w_issue) begin
         mem_en   = 1'b1;
         mem_addr = {r_addr[ADDR_W-1:LOW_W], r_issue_cnt, 1'b0};
      end
   end

   assign fill_data     = mem_rdata;
   assign fill_word_idx = r_ret_cnt;
   assign i_fill_we     = w_ret && (r_state == S_FILL_I);
   assign d_fill_we     = w_ret && (r_state == S_FILL_D);
   assign i_fill_done   = w_last_ret && (r_state == S_FILL_I);
   assign d_fill_done   = w_last_ret && (r_state == S_FILL_D);
   assign d_write_done  = (r_state == S_WRITE);
   assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
`timescale 1ns/1ps
module tb_mem_arbiter_ctrl;

   localparam int          ADDR_W   = 16;
   localparam int          DATA_W   = 16;
   localparam int          BLK      = 8;
   localparam logic [15:0] BLK_MASK = 16'hFFF0;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_miss = 1'b0, d_miss = 1'b0, d_write = 1'b0;
   logic [ADDR_W-1:0] i_miss_addr = '0, d_miss_addr = '0, d_write_addr = '0;
   logic [DATA_W-1:0] d_write_data = '0;
   logic              mem_en, mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_data_valid = 1'b0;
   logic [DATA_W-1:0] fill_data;
   logic [2:0]        fill_word_idx;
   logic              i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_write_done, busy;

   always #5 clk = ~clk;

   mem_arbiter_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLK_WORDS(BLK)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_miss(i_miss), .i_miss_addr(i_miss_addr),
      .d_miss(d_miss), .d_miss_addr(d_miss_addr),
      .d_write(d_write), .d_write_addr(d_write_addr), .d_write_data(d_write_data),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
      .fill_data(fill_data), .fill_word_idx(fill_word_idx),
      .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
      .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
      .d_write_done(d_write_done), .busy(busy)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int          cyc = 0;
   int          lat = 4;
   bit          spur_en = 1'b0;
   bit          hold = 1'b0;
   int          n_iwe = 0, n_dwe = 0;
   string       evlog = "";

   // Requester intentions, applied to the DUT at the next falling edge.
   logic        q_w = 1'b0, q_d = 1'b0, q_i = 1'b0;
   logic [15:0] q_waddr = '0, q_wdata = '0, q_daddr = '0, q_iaddr = '0;

   // Memory: in-order returns, each due a fixed latency after its issue cycle.
   typedef struct { int due; logic [15:0] data; } ret_t;
   ret_t mq[$];

   // Transaction-level reference: what the port is currently serving.
   typedef enum { K_NONE, K_WRITE, K_FILL_I, K_FILL_D } kind_e;
   kind_e       m_kind = K_NONE;
   int          m_start = 0, m_ret = 0;
   logic [15:0] m_addr = '0, m_data = '0;
   bit          m_last_d = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      int          off;
      bit          e_en, e_iwe, e_dwe, e_id, e_dd, e_wd, pick_d;
      logic [15:0] e_addr, e_wdat;
      ret_t        r;
      @(negedge clk);
      cyc++;
      d_write = q_w; d_write_addr = q_waddr; d_write_data = q_wdata;
      d_miss  = q_d; d_miss_addr  = q_daddr;
      i_miss  = q_i; i_miss_addr  = q_iaddr;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
         r = mq.pop_front();
         mem_data_valid = 1'b1;
         mem_rdata      = r.data;
      end else begin
         mem_data_valid = spur_en && mq.size() == 0 &&
                          (m_kind == K_NONE || m_kind == K_WRITE) && ($urandom_range(3) == 0);
         mem_rdata      = 16'($urandom);
      end
      #1;
      e_en = 0; e_iwe = 0; e_dwe = 0; e_id = 0; e_dd = 0; e_wd = 0;
      e_addr = '0; e_wdat = '0;
      if (rst_n) begin
         case (m_kind)
            K_WRITE: begin
               e_en = 1; e_addr = m_addr; e_wdat = m_data; e_wd = 1;
            end
            K_FILL_I, K_FILL_D: begin
               off = cyc - m_start;
               if (off < BLK) begin
                  e_en = 1; e_addr = (m_addr & BLK_MASK) + 16'(2 * off);
               end
               if (mem_data_valid) begin
                  if (m_kind == K_FILL_I) begin
                     e_iwe = 1; e_id = (m_ret == BLK - 1);
                  end else begin
                     e_dwe = 1; e_dd = (m_ret == BLK - 1);
                  end
               end
            end
            default: ;
         endcase
      end
      chk("busy", busy, rst_n && m_kind != K_NONE);
      chk("mem_en", mem_en, e_en);
      if (e_en) begin
         chk("mem_wr", mem_wr, m_kind == K_WRITE);
         chk("mem_addr", mem_addr, e_addr);
      end
      chk("mem_wdata", mem_wdata, e_wdat);
      chk("i_fill_we", i_fill_we, e_iwe);
      chk("d_fill_we", d_fill_we, e_dwe);
      chk("i_fill_done", i_fill_done, e_id);
      chk("d_fill_done", d_fill_done, e_dd);
      chk("d_write_done", d_write_done, e_wd);
      if (e_iwe || e_dwe) begin
         chk("fill_word_idx", fill_word_idx, 32'(m_ret));
         chk("fill_data", fill_data, mem_rdata);
      end
      if (mem_en && !mem_wr) mq.push_back('{due: cyc + lat, data: 16'($urandom)});
      if (i_fill_we) n_iwe++;
      if (d_fill_we) n_dwe++;
      if (d_write_done) evlog = {evlog, "W"};
      if (d_fill_done)  evlog = {evlog, "D"};
      if (i_fill_done)  evlog = {evlog, "I"};
      if (!rst_n) begin
         m_kind = K_NONE; m_last_d = 1'b0;
      end else begin
         case (m_kind)
            K_NONE: begin
               if (q_w) begin
                  m_kind = K_WRITE; m_addr = q_waddr; m_data = q_wdata;
               end else if (q_d || q_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                  pick_d = q_d && (!q_i || !m_last_d);
`else
                  pick_d = q_d;
`endif
                  m_kind   = pick_d ? K_FILL_D : K_FILL_I;
                  m_addr   = pick_d ? q_daddr : q_iaddr;
                  m_last_d = pick_d;
                  m_start  = cyc + 1;
                  m_ret    = 0;
               end
            end
            K_WRITE: m_kind = K_NONE;
            default: if (mem_data_valid) begin
               m_ret++;
               if (m_ret == BLK) m_kind = K_NONE;
            end
         endcase
      end
      if (!hold) begin
         if (e_wd) q_w = 1'b0;
         if (e_dd) q_d = 1'b0;
         if (e_id) q_i = 1'b0;
      end
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((m_kind != K_NONE || mq.size() != 0 || q_w || q_d || q_i) && n < max) begin
         step(); n++;
      end
      n_vec++;
      assert (n < max) else begin
         n_err++;
         $error("FAIL drain_timeout observed=%0d expected_below=%0d", n, max);
      end
   endtask

   task automatic random_phase(input int cycles);
      for (int n = 0; n < cycles; n++) begin
         if (!q_w && $urandom_range(7) == 0) begin
            q_w = 1'b1; q_waddr = 16'($urandom); q_wdata = 16'($urandom);
         end
         if (!q_d && $urandom_range(9) == 0) begin
            q_d = 1'b1; q_daddr = 16'($urandom);
         end
         if (!q_i && $urandom_range(9) == 0) begin
            q_i = 1'b1; q_iaddr = 16'($urandom);
         end
         step();
      end
   endtask

   initial begin
      int    t_grant, t_done, n, dwe_before;
      string exp_s;

      // 1: reset then 20 idle cycles
      for (int k = 0; k < 3; k++) step();
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) step();

      // 2: single store
      q_w = 1'b1; q_waddr = 16'h1234; q_wdata = 16'hBEEF;
      step();
      step();
      chk("t2_wr", mem_wr, 1'b1);
      chk("t2_addr", mem_addr, 16'h1234);
      chk("t2_wdata", mem_wdata, 16'hBEEF);
      drain(20);

      // 3: I-fill with latency 4
      lat = 4; n_iwe = 0;
      q_i = 1'b1; q_iaddr = 16'h0046;
      step();
      t_grant = cyc; t_done = -1; n = 0;
      while (t_done < 0 && n < 60) begin
         step(); n++;
         if (i_fill_done) t_done = cyc;
      end
      chk("t3_done_latency", 32'(t_done - t_grant), 32'd12);
      step();
      chk("t3_busy_after", busy, 1'b0);
      chk("t3_we_count", 32'(n_iwe), 32'd8);
      drain(60);

      // 4: all three requests together
      evlog = "";
      q_w = 1'b1; q_waddr = 16'h0100; q_wdata = 16'h5A5A;
      q_d = 1'b1; q_daddr = 16'h2222;
      q_i = 1'b1; q_iaddr = 16'h3333;
      drain(200);
      exp_s = "WDI";
      n_vec++;
      assert (evlog == exp_s) else begin
         n_err++; $error("FAIL t4_order observed=%s expected=%s", evlog, exp_s);
      end

      // 5: both fill requests held continuously
      evlog = ""; hold = 1'b1;
      q_d = 1'b1; q_daddr = 16'h4440; q_i = 1'b1; q_iaddr = 16'h8880;
      n = 0;
      while (evlog.len() < 4 && n < 300) begin
         step(); n++;
      end
      hold = 1'b0; q_d = 1'b0; q_i = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      exp_s = "DIDI";
`else
      exp_s = "DDDD";
`endif
      n_vec++;
      assert (evlog == exp_s) else begin
         n_err++; $error("FAIL t5_order observed=%s expected=%s", evlog, exp_s);
      end
      drain(60);

      // 6: reset in the middle of a D-fill after three returns
      lat = 6;
      q_d = 1'b1; q_daddr = 16'($urandom);
      n = 0;
      while (!(m_kind == K_FILL_D && m_ret == 3) && n < 60) begin
         step(); n++;
      end
      chk("t6_reached", 32'(m_ret), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("t6_busy", busy, 1'b0);
      chk("t6_mem_en", mem_en, 1'b0);
      chk("t6_mem_wr", mem_wr, 1'b0);
      chk("t6_mem_addr", mem_addr, 16'h0000);
      chk("t6_mem_wdata", mem_wdata, 16'h0000);
      chk("t6_d_fill_we", d_fill_we, 1'b0);
      chk("t6_d_fill_done", d_fill_done, 1'b0);
      chk("t6_idx", fill_word_idx, 3'd0);
      m_kind = K_NONE; m_last_d = 1'b0; q_d = 1'b0;
      chk("t6_late_pending", 32'(mq.size() > 0), 32'd1);
      step();
      rst_n = 1'b1;
      dwe_before = n_dwe;
      for (int k = 0; k < 12; k++) step();
      chk("t6_no_late_we", 32'(n_dwe), 32'(dwe_before));
      drain(20);

      // randomized traffic at two memory latencies, with stray valids
      spur_en = 1'b1;
      lat = 1;
      random_phase(400);
      drain(300);
      lat = 5;
      random_phase(400);
      drain(300);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

endmodule
